bb_glb_ctrl: RTL and testbench

Parametrised successor to the baseband global-control logic. It holds the global registers (enable, measurement/request counters, interrupt flags and mask) and generates the tracking-engine start pulse and the level IRQ. Differences from the current generation:
- counter widths are set by parameters;
- interrupt source count is set by a parameter;
- auto-restart of the tracking engine (TE) is gated by te_enable.

It sits between the host register decode and the TE/AE blocks at top level.

---
 rtl/bb_glb_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_bb_glb_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_glb_ctrl.sv
// rtl/bb_glb_ctrl.sv - baseband global control registers, TE start pulse and level IRQ (optional INT_COALESCE_EN)
module bb_glb_ctrl #(
    parameter int NUM_INT = 8,
    parameter int CNT_W   = 10,
    parameter int COAL_W  = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               host_cs,
    input  logic               host_rd,
    input  logic               host_wr,
    input  logic [4:0]         host_addr,
    input  logic [31:0]        host_d4wt,
    output logic [31:0]        host_d4rd,
    input  logic               te_running,
    input  logic               te_over,
    input  logic               te_ready,
    input  logic [NUM_INT-4:0] ext_event,
    output logic               te_enable,
    output logic               te_start,
    output logic [NUM_INT-1:0] int_flag,
    output logic               irq
);

    localparam logic [4:0] A_ENABLE   = 5'd0;
    localparam logic [4:0] A_START    = 5'd1;
    localparam logic [4:0] A_MEAS_NUM = 5'd2;
    localparam logic [4:0] A_MEAS_CNT = 5'd3;
    localparam logic [4:0] A_INT_FLAG = 5'd4;
    localparam logic [4:0] A_REQ_CNT  = 5'd5;
    localparam logic [4:0] A_INT_MASK = 5'd6;
    localparam logic [4:0] A_COALESCE = 5'd7;

    logic               wr_en;
    logic               rd_en;
    logic [CNT_W-1:0]   meas_number;
    logic [CNT_W-1:0]   meas_count;
    logic [CNT_W-1:0]   request_count;
    logic [CNT_W-1:0]   meas_inc;
    logic               meas_hit;
    logic [NUM_INT-1:0] int_mask;
    logic [NUM_INT-1:0] flag_set;
    logic [NUM_INT-1:0] flag_clr;
    logic               set_data_ready;
    logic               te_over_d;
    logic               auto_start;
    logic               cpu_start;
    logic [31:0]        coal_rd;
    logic [31:0]        rd_val;
    logic               unused_wdata;

    assign wr_en    = host_cs & host_wr;
    assign rd_en    = host_cs & host_rd;
    assign meas_inc = meas_count + CNT_W'(1);
    assign meas_hit = (meas_inc == meas_number);

    // Not every write-data bit lands in a register for every parameter set.
    assign unused_wdata = ^host_d4wt;

`ifdef INT_COALESCE_EN
    logic [COAL_W-1:0] coal_th;
    logic [COAL_W-1:0] coal_cnt;
    logic [COAL_W-1:0] coal_inc;
    logic              coal_ev;

    assign coal_ev        = te_over & te_ready;
    assign coal_inc       = coal_cnt + COAL_W'(1);
    assign set_data_ready = coal_ev & ((coal_th <= COAL_W'(1)) | (coal_inc == coal_th));
    assign coal_rd        = 32'(coal_th);

    // Coalescing threshold and event counter; a threshold write restarts the count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            coal_th  <= '0;
            coal_cnt <= '0;
        end else if (wr_en && host_addr == A_COALESCE) begin
            coal_th  <= host_d4wt[COAL_W-1:0];
            coal_cnt <= '0;
        end else if (coal_ev) begin
            coal_cnt <= set_data_ready ? '0 : coal_inc;
        end
    end
`else
    logic [COAL_W-1:0] unused_coal;

    assign unused_coal    = '0;
    assign set_data_ready = te_over & te_ready;
    assign coal_rd        = '0;
`endif

    // Flags are evaluated on the counter values before this cycle's update.
    assign flag_set = {ext_event,
                       te_over & (request_count == CNT_W'(1)),
                       te_over & meas_hit,
                       set_data_ready};
    assign flag_clr = (wr_en && host_addr == A_INT_FLAG) ? host_d4wt[NUM_INT+7:8] : '0;

    assign auto_start = te_over_d & te_enable & ~(|int_flag[2:0]);
    assign cpu_start  = wr_en & (host_addr == A_START) & host_d4wt[0] & ~te_running;

    // Read-data mux; unmapped addresses and unused bits read as zero.
    always_comb begin
        rd_val = '0;
        case (host_addr)
            A_ENABLE:   rd_val[8] = te_enable;
            A_START:    rd_val[0] = te_running;
            A_MEAS_NUM: rd_val[CNT_W-1:0] = meas_number;
            A_MEAS_CNT: rd_val[CNT_W-1:0] = meas_count;
            A_INT_FLAG: rd_val[NUM_INT+7:8] = int_flag;
            A_REQ_CNT:  rd_val[CNT_W-1:0] = request_count;
            A_INT_MASK: rd_val[NUM_INT+7:8] = int_mask;
            A_COALESCE: rd_val = coal_rd;
            default:    rd_val = '0;
        endcase
    end

    // Registered read data, zero whenever no read is in progress.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            host_d4rd <= '0;
        end else begin
            host_d4rd <= rd_en ? rd_val : '0;
        end
    end

    // Plain host read/write registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            te_enable   <= 1'b0;
            meas_number <= '0;
            int_mask    <= '0;
        end else if (wr_en) begin
            if (host_addr == A_ENABLE)   te_enable   <= host_d4wt[8];
            if (host_addr == A_MEAS_NUM) meas_number <= host_d4wt[CNT_W-1:0];
            if (host_addr == A_INT_MASK) int_mask    <= host_d4wt[NUM_INT+7:8];
        end
    end

    // Measurement counter: wraps to 0 on a meas_number hit, host write wins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meas_count <= '0;
        end else if (wr_en && host_addr == A_MEAS_CNT) begin
            meas_count <= host_d4wt[CNT_W-1:0];
        end else if (te_over) begin
            meas_count <= meas_hit ? '0 : meas_inc;
        end
    end

    // Request counter: counts down to 0 and holds there, host write wins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            request_count <= '0;
        end else if (wr_en && host_addr == A_REQ_CNT) begin
            request_count <= host_d4wt[CNT_W-1:0];
        end else if (te_over && request_count != '0) begin
            request_count <= request_count - CNT_W'(1);
        end
    end

    // Sticky flags: W1C clear, with a same-cycle set taking precedence.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            int_flag <= '0;
        end else begin
            int_flag <= (int_flag & ~flag_clr) | flag_set;
        end
    end

    // TE start pulse from auto-restart or host start; both merge into one pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            te_over_d <= 1'b0;
            te_start  <= 1'b0;
        end else begin
            te_over_d <= te_over;
            te_start  <= auto_start | cpu_start;
        end
    end

    // Level interrupt, one cycle behind the flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            irq <= 1'b0;
        end else begin
            irq <= |(int_flag & int_mask);
        end
    end

endmodule

// File: tb/tb_bb_glb_ctrl.sv
// tb/tb_bb_glb_ctrl.sv - scoreboard testbench for bb_glb_ctrl with a behavioural register model
module tb_bb_glb_ctrl;

    localparam int NUM_INT = 8;
    localparam int CNT_W   = 10;
    localparam int COAL_W  = 4;
    localparam int unsigned CM = 1 << CNT_W;
    localparam int unsigned KM = 1 << COAL_W;
    localparam int unsigned FM = (1 << NUM_INT) - 1;

    logic               clk = 1'b0;
    logic               rst_b = 1'b0;
    logic               host_cs = 1'b0;
    logic               host_rd = 1'b0;
    logic               host_wr = 1'b0;
    logic [4:0]         host_addr = '0;
    logic [31:0]        host_d4wt = '0;
    logic [31:0]        host_d4rd;
    logic               te_running = 1'b0;
    logic               te_over = 1'b0;
    logic               te_ready = 1'b0;
    logic [NUM_INT-4:0] ext_event = '0;
    logic               te_enable;
    logic               te_start;
    logic [NUM_INT-1:0] int_flag;
    logic               irq;

    bb_glb_ctrl #(.NUM_INT(NUM_INT), .CNT_W(CNT_W), .COAL_W(COAL_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .host_cs(host_cs), .host_rd(host_rd), .host_wr(host_wr),
        .host_addr(host_addr), .host_d4wt(host_d4wt), .host_d4rd(host_d4rd),
        .te_running(te_running), .te_over(te_over), .te_ready(te_ready),
        .ext_event(ext_event), .te_enable(te_enable), .te_start(te_start),
        .int_flag(int_flag), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] rd;
        bit        start;
        bit        irq;
        bit        en;
        bit [31:0] flags;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad   = 0;

    // Reference state (value held after the most recent clock edge)
    int unsigned m_en, m_mn, m_mc, m_rc, m_flags, m_mask, m_th, m_cnt, m_over_d;

    task automatic check(input string name, input bit [31:0] got, input bit [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic int unsigned read_model(input int unsigned a);
        case (a)
            0: return m_en << 8;
            1: return int'(te_running);
            2: return m_mn;
            3: return m_mc;
            4: return m_flags << 8;
            5: return m_rc;
            6: return m_mask << 8;
`ifdef INT_COALESCE_EN
            7: return m_th;
`endif
            default: return 0;
        endcase
    endfunction

    // Predict outputs after the coming edge, push them, advance model, wait one cycle.
    task automatic step();
        exp_t e;
        bit w, r, ev, dset;
        int unsigned a, d, set, clr;
        w  = host_cs && host_wr;
        r  = host_cs && host_rd;
        a  = host_addr;
        d  = host_d4wt;
        ev = te_over && te_ready;
        e.rd    = r ? read_model(a) : 0;
        e.start = (m_over_d == 1 && m_en == 1 && (m_flags & 7) == 0) ||
                  (w && a == 1 && d[0] && !te_running);
        e.irq   = (m_flags & m_mask) != 0;
`ifdef INT_COALESCE_EN
        dset = ev && (m_th <= 1 || m_cnt + 1 == m_th);
        if (w && a == 7) begin
            m_th  = d % KM;
            m_cnt = 0;
        end else if (ev) begin
            m_cnt = dset ? 0 : m_cnt + 1;
        end
`else
        dset = ev;
`endif
        set = int'(dset);
        if (te_over && ((m_mc + 1) % CM) == m_mn) set |= 2;
        if (te_over && m_rc == 1) set |= 4;
        set |= int'(ext_event) << 3;
        clr = (w && a == 4) ? ((d >> 8) & FM) : 0;
        m_flags = ((m_flags & ~clr) | set) & FM;
        if (w && a == 3)   m_mc = d % CM;
        else if (te_over)  m_mc = (((m_mc + 1) % CM) == m_mn) ? 0 : (m_mc + 1) % CM;
        if (w && a == 5)   m_rc = d % CM;
        else if (te_over && m_rc > 0) m_rc = m_rc - 1;
        if (w && a == 0) m_en = (d >> 8) & 1;
        if (w && a == 2) m_mn = d % CM;
        if (w && a == 6) m_mask = (d >> 8) & FM;
        m_over_d = int'(te_over);
        e.en    = m_en[0];
        e.flags = m_flags;
        sb_q.push_back(e);
        @(negedge clk);
        host_cs = 0; host_rd = 0; host_wr = 0;
        te_over = 0; te_ready = 0; ext_event = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int unsigned a, input int unsigned d);
        host_cs = 1; host_wr = 1; host_addr = 5'(a); host_d4wt = d;
        step();
    endtask

    task automatic rd(input int unsigned a);
        host_cs = 1; host_rd = 1; host_addr = 5'(a);
        step();
    endtask

    task automatic over(input bit rdy);
        te_over = 1; te_ready = rdy;
        step();
    endtask

    // Monitor: pops one expectation per cycle just after the edge and compares.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("host_d4rd", host_d4rd, e.rd);
                check("te_start", 32'(te_start), 32'(e.start));
                check("irq", 32'(irq), 32'(e.irq));
                check("te_enable", 32'(te_enable), 32'(e.en));
                check("int_flag", 32'(int_flag), e.flags);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        m_en = 0; m_mn = 0; m_mc = 0; m_rc = 0; m_flags = 0;
        m_mask = 0; m_th = 0; m_cnt = 0; m_over_d = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", host_d4rd, 0);
        check("reset_start", 32'(te_start), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_flag", 32'(int_flag), 0);
        check("reset_en", 32'(te_enable), 0);
        @(negedge clk);
        rst_b = 1;

        // All registers read zero after reset
        for (int a = 0; a < 8; a++) rd(a);

        // Measurement wrap at meas_number = 3 with auto-restart
        wr(2, 3); wr(0, 32'h100); wr(6, 32'h200);
        for (int i = 0; i < 3; i++) begin
            over(0); idle(2); rd(3);
        end
        idle(2);
        wr(4, 32'hFFFF_FF00); idle(1);

        // Request countdown and saturation
        wr(5, 2);
        for (int i = 0; i < 3; i++) begin
            over(0); idle(1); rd(5);
        end
        wr(4, 32'hFFFF_FF00); idle(1);

        // ext_event set beats a same-cycle W1C
        wr(6, 32'h800);
        ext_event = 1; host_cs = 1; host_wr = 1; host_addr = 4; host_d4wt = 32'h800;
        step();
        idle(2);
        wr(4, 32'h800); idle(3);

        // Host start gated by te_running; no auto-restart when disabled
        te_running = 1; wr(1, 1); idle(2); rd(1);
        te_running = 0; wr(1, 1); idle(2);
        wr(2, 0); wr(0, 0); wr(4, 32'hFFFF_FF00);
        over(0); idle(3);

        // data_ready events (coalesced at threshold 3 when enabled)
        wr(7, 3); rd(7);
        for (int i = 0; i < 4; i++) begin
            over(1); idle(2);
        end
        wr(4, 32'hFFFF_FF00); idle(1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned a;
            te_running = ($urandom % 4) == 0;
            te_over    = ($urandom % 5) == 0;
            te_ready   = $urandom % 2;
            ext_event  = (($urandom % 10) == 0) ? (NUM_INT-3)'($urandom) : '0;
            host_cs    = $urandom % 2;
            host_rd    = $urandom % 2;
            host_wr    = ($urandom % 4) == 0;
            a          = $urandom % 10;
            host_addr  = 5'(a);
            if (a == 2 || a == 5 || a == 7) host_d4wt = $urandom % 6;
            else host_d4wt = $urandom;
            step();
        end

        idle(2);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
